// File: rtl/em_pipe_pkg.sv
// em_pipe_pkg
//   Constants and types shared by the pipeline registers of the core
//   (F/D, D/E, E/M, M/W).
//   - DATA_W_DEF : default datapath width (ALU result, address)
//   - REG_W_DEF  : default register index width (16-entry register file)
//   - em_ctrl_t  : bundled E/M control bits, available to stage logic
package em_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  typedef struct packed {
    logic pcload;
    logic regw;
    logic memw;
    logic regmem;
  } em_ctrl_t;

  // All-zero control word: no PC load, no register write, no memory write.
  localparam em_ctrl_t EM_CTRL_BUBBLE = '0;

endpackage

// File: rtl/em_pipe.sv
// em_pipe
//   Execute-to-Memory pipeline register. Every output is a flop that loads
//   its matching Execute-stage input on each rising clk edge, so the bundle
//   appears at the Memory stage exactly one cycle later. A synchronous
//   active-high rst loads the all-zero bundle, which is a pipeline bubble.
//
//   Ports
//     clk        in   system clock, rising-edge
//     rst        in   synchronous reset, active-high
//     pcload_E   in   write-PC control
//     regw_E     in   register-file write enable
//     memw_E     in   data-memory write enable
//     regmem_E   in   write-back select (1 = memory data, 0 = ALU result)
//     regScr_E   in   destination register index   [REG_W]
//     ALUrslt_E  in   ALU result                   [DATA_W]
//     address_E  in   memory address / store data  [DATA_W]
//     *_M        out  registered copies of the *_E inputs
module em_pipe
  import em_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcload_E,
  input  logic              regw_E,
  input  logic              memw_E,
  input  logic              regmem_E,
  input  logic [REG_W-1:0]  regScr_E,
  input  logic [DATA_W-1:0] ALUrslt_E,
  input  logic [DATA_W-1:0] address_E,
  output logic              pcload_M,
  output logic              regw_M,
  output logic              memw_M,
  output logic              regmem_M,
  output logic [REG_W-1:0]  regScr_M,
  output logic [DATA_W-1:0] ALUrslt_M,
  output logic [DATA_W-1:0] address_M
);

  em_ctrl_t          ctrl_d,    ctrl_q;
  logic [REG_W-1:0]  regscr_d,  regscr_q;
  logic [DATA_W-1:0] alurslt_d, alurslt_q;
  logic [DATA_W-1:0] address_d, address_q;

  // No enable or stall: the next state is always the current Execute bundle.
  always_comb begin
    ctrl_d.pcload = pcload_E;
    ctrl_d.regw   = regw_E;
    ctrl_d.memw   = memw_E;
    ctrl_d.regmem = regmem_E;
    regscr_d      = regScr_E;
    alurslt_d     = ALUrslt_E;
    address_d     = address_E;
  end

  // Reset takes priority over capture; inputs seen at a reset edge are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= EM_CTRL_BUBBLE;
      regscr_q  <= '0;
      alurslt_q <= '0;
      address_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      regscr_q  <= regscr_d;
      alurslt_q <= alurslt_d;
      address_q <= address_d;
    end
  end

  assign pcload_M  = ctrl_q.pcload;
  assign regw_M    = ctrl_q.regw;
  assign memw_M    = ctrl_q.memw;
  assign regmem_M  = ctrl_q.regmem;
  assign regScr_M  = regscr_q;
  assign ALUrslt_M = alurslt_q;
  assign address_M = address_q;

endmodule

// File: tb/tb_em_pipe.sv
// tb_em_pipe
//   Directed bench for em_pipe. Each driven bundle pushes its expected
//   output (zero when rst is high) onto a queue; after the next rising edge
//   the head is popped and compared with the concatenated _M outputs.
module tb_em_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;
  localparam int BW     = 4 + REG_W + 2 * DATA_W;

  logic              clk;
  logic              rst;
  logic              pcload_E, regw_E, memw_E, regmem_E;
  logic [REG_W-1:0]  regScr_E;
  logic [DATA_W-1:0] ALUrslt_E, address_E;
  logic              pcload_M, regw_M, memw_M, regmem_M;
  logic [REG_W-1:0]  regScr_M;
  logic [DATA_W-1:0] ALUrslt_M, address_M;

  int n_vec = 0;
  int n_err = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] last_exp;

  em_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pcload_E  (pcload_E),
    .regw_E    (regw_E),
    .memw_E    (memw_E),
    .regmem_E  (regmem_E),
    .regScr_E  (regScr_E),
    .ALUrslt_E (ALUrslt_E),
    .address_E (address_E),
    .pcload_M  (pcload_M),
    .regw_M    (regw_M),
    .memw_M    (memw_M),
    .regmem_M  (regmem_M),
    .regScr_M  (regScr_M),
    .ALUrslt_M (ALUrslt_M),
    .address_M (address_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] outs();
    return {pcload_M, regw_M, memw_M, regmem_M, regScr_M, ALUrslt_M, address_M};
  endfunction

  task automatic drive(input logic r, input logic [BW-1:0] v);
    rst = r;
    {pcload_E, regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E} = v;
    exp_q.push_back(r ? '0 : v);
  endtask

  task automatic check(input string tag);
    logic [BW-1:0] obs;
    logic [BW-1:0] exp;
    obs = outs();
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    last_exp = exp;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full cycle: drive on the falling edge, check 1 time unit after the rise.
  task automatic step(input logic r, input logic [BW-1:0] v, input string tag);
    @(negedge clk);
    drive(r, v);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  function automatic logic [BW-1:0] pack(input logic pl, input logic rw, input logic mw,
                                         input logic rm, input logic [REG_W-1:0] rs,
                                         input logic [DATA_W-1:0] alu,
                                         input logic [DATA_W-1:0] adr);
    return {pl, rw, mw, rm, rs, alu, adr};
  endfunction

  initial begin
    logic [BW-1:0] v;
    logic [BW-1:0] obs;
    rst = 1'b1;
    {pcload_E, regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E} = '0;
    last_exp = '0;

    // Reset with every input at all-ones.
    step(1'b1, '1, "reset_all_ones");

    // Basic capture, then a back-to-back bundle.
    step(1'b0, pack(1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000FFFF, 32'h00010004), "capture_1");
    step(1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 32'h0000FFFF, 32'h00000000), "capture_2");
    step(1'b0, pack(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 32'h12345678, 32'h9ABCDEF0), "capture_3");

    // Glitch ALUrslt_E between edges; outputs must hold the previous bundle.
    @(negedge clk);
    v = pack(1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 32'hCAFEF00D, 32'h00000040);
    drive(1'b0, v);
    #1 ALUrslt_E = 32'h5A5A5A5A;
    #1;
    obs = outs();
    n_vec++;
    assert (obs === last_exp) else begin
      n_err++;
      $error("FAIL glitch_hold: observed %h expected %h", obs, last_exp);
    end
    #1 ALUrslt_E = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("glitch_capture");

    // Mid-stream reset discards DEADBEEF; release captures the current inputs.
    step(1'b0, pack(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0BADF00D, 32'h0000_1000), "pre_reset");
    step(1'b1, pack(1'b1, 1'b1, 1'b1, 1'b1, 4'b1001, 32'hDEADBEEF, 32'hDEADBEEF), "midstream_reset");
    step(1'b0, pack(1'b0, 1'b1, 1'b0, 1'b1, 4'b0101, 32'hDEADBEEF, 32'h0000_2000), "post_reset");

    // Walking one across every bit of the bundle, back to back.
    for (int i = 0; i < BW; i++) begin
      v = '0;
      v[i] = 1'b1;
      step(1'b0, v, $sformatf("walk1_bit%0d", i));
    end

    // Walking zero through an otherwise all-ones bundle.
    for (int i = 0; i < BW; i += 7) begin
      v = '1;
      v[i] = 1'b0;
      step(1'b0, v, $sformatf("walk0_bit%0d", i));
    end

    // Random back-to-back bundles with occasional resets.
    for (int i = 0; i < 40; i++) begin
      v = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 7) == 0), v, $sformatf("rand_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end

endmodule
